// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Register file geometry, default requester count and pointer-width helper.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR = 5;
    localparam int REG_SIZE = 32;
    localparam int REG_N    = 32;
    localparam int WB_NREQ  = 3;

    function automatic int wb_ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Grant selector for the writeback holds: onehot grant plus winner index.
// Ports: i_req (held writes), i_ptr (last winner) -> o_grant, o_winner, o_any.
// Config macro WB_FIXED_PRIO_EN: lowest index always wins, i_ptr ignored.
module wb_rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = WB_NREQ,
    parameter int PW   = wb_ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_winner,
    output logic            o_any
);

`ifdef WB_FIXED_PRIO_EN
    always_comb begin
        o_grant  = '0;
        o_winner = '0;
        // Scan downwards so the lowest requesting index is the last write.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
                o_winner   = PW'(i);
            end
        end
    end
`else
    logic w_found;
    int   w_idx;

    always_comb begin
        o_grant  = '0;
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        // Search starts one past the previous winner.
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_winner       = PW'(w_idx);
            end
        end
    end
`endif

    assign o_any = |i_req;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NREQ writeback sources.
// Ports: clk, reset (async active-low); req_valid/ready/wreg/wdata per source;
// regwrite/wreg/wdata to the regfile; pend_mask, busy for hazard logic.
// Config macro WB_FIXED_PRIO_EN selects fixed priority in wb_rr_arbiter.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = WB_NREQ,
    parameter int AW   = REG_ADDR,
    parameter int DW   = REG_SIZE,
    parameter int NREG = REG_N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_wreg,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic             regwrite,
    output logic [AW-1:0]    wreg,
    output logic [DW-1:0]    wdata,
    output logic [NREG-1:0]  pend_mask,
    output logic             busy
);

    localparam int PW = wb_ptr_w(NREQ);

    logic [NREQ-1:0] r_hold_v;
    logic [AW-1:0]   r_hold_wreg  [NREQ];
    logic [DW-1:0]   r_hold_wdata [NREQ];
    logic [PW-1:0]   r_rr_ptr;
    logic            r_regwrite;
    logic [AW-1:0]   r_wreg;
    logic [DW-1:0]   r_wdata;

    logic [AW-1:0]   w_src_wreg  [NREQ];
    logic [DW-1:0]   w_src_wdata [NREQ];
    logic [NREQ-1:0] w_grant;
    logic [NREQ-1:0] w_ready;
    logic [NREQ-1:0] w_load;
    logic [PW-1:0]   w_winner;
    logic            w_any;
    logic [NREG-1:0] w_pend;

    wb_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .i_req    (r_hold_v),
        .i_ptr    (r_rr_ptr),
        .o_grant  (w_grant),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_src_wreg[i]  = req_wreg[i*AW +: AW];
            w_src_wdata[i] = req_wdata[i*DW +: DW];
        end
    end

    // A hold being drained this cycle can take a new write.
    assign w_ready = ~r_hold_v | w_grant;

    // Writes to r0 are acknowledged but never held.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_load[i] = req_valid[i] & w_ready[i] &
                        (w_src_wreg[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_v <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_load[i]) begin
                    r_hold_v[i] <= 1'b1;
                end else if (w_grant[i]) begin
                    r_hold_v[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (w_load[i]) begin
                r_hold_wreg[i]  <= w_src_wreg[i];
                r_hold_wdata[i] <= w_src_wdata[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regwrite <= 1'b0;
            r_wreg     <= '0;
            r_wdata    <= '0;
            r_rr_ptr   <= PW'(NREQ - 1);
        end else begin
            r_regwrite <= w_any;
            if (w_any) begin
                r_wreg   <= r_hold_wreg[w_winner];
                r_wdata  <= r_hold_wdata[w_winner];
                r_rr_ptr <= w_winner;
            end
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_hold_v[i]) begin
                w_pend[r_hold_wreg[i]] = 1'b1;
            end
        end
        if (r_regwrite) begin
            w_pend[r_wreg] = 1'b1;
        end
        w_pend[0] = 1'b0;
    end

    assign req_ready = w_ready;
    assign regwrite  = r_regwrite;
    assign wreg      = r_wreg;
    assign wdata     = r_wdata;
    assign pend_mask = w_pend;
    assign busy      = (|r_hold_v) | r_regwrite;

endmodule
